// File: rtl/baccarat_autoplay.sv
// Autoplay sequencer for a baccarat game: pulses the game's reset and step inputs,
// waits for each round result and keeps per-session win/tie statistics.
module baccarat_autoplay (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  num_rounds,
    input  logic [15:0] half_period,
    input  logic        game_done,
    input  logic        player_win,
    input  logic        dealer_win,
    output logic        slow_clock,
    output logic        game_resetb,
    output logic        busy,
    output logic        err,
    output logic [7:0]  round_count,
    output logic [7:0]  pwin_count,
    output logic [7:0]  dwin_count,
    output logic [7:0]  tie_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LO,
        S_RST_HI,
        S_STEP_LO,
        S_STEP_HI,
        S_CHECK,
        S_TALLY,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] MAX_STEPS = 4'd8;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] hp_q, hp_d;
    logic [3:0]  step_q, step_d;
    logic        err_q, err_d;
    logic [7:0]  round_q, round_d;
    logic [7:0]  pwin_q, pwin_d;
    logic [7:0]  dwin_q, dwin_d;
    logic [7:0]  tie_q, tie_d;

    logic [15:0] hp_load;
    logic [7:0]  round_next;
    logic        timer_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        hp_d       = hp_q;
        step_d     = step_q;
        err_d      = err_q;
        round_d    = round_q;
        pwin_d     = pwin_q;
        dwin_d     = dwin_q;
        tie_d      = tie_q;
        hp_load    = (half_period < 16'd2) ? 16'd2 : half_period;
        round_next = sat_inc(round_q);
        timer_done = (timer_q == 16'd0);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_RST_LO;
                    hp_d    = hp_load;
                    timer_d = hp_load - 16'd1;
                    step_d  = '0;
                    err_d   = 1'b0;
                    round_d = '0;
                    pwin_d  = '0;
                    dwin_d  = '0;
                    tie_d   = '0;
                end
            end
            S_RST_LO: begin
                step_d = '0;
                if (timer_done) begin
                    state_d = S_RST_HI;
                    timer_d = hp_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_RST_HI: begin
                if (timer_done) begin
                    state_d = S_STEP_LO;
                    timer_d = hp_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STEP_LO: begin
                if (timer_done) begin
                    state_d = S_STEP_HI;
                    timer_d = hp_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STEP_HI: begin
                if (timer_done) begin
                    state_d = S_CHECK;
                    step_d  = step_q + 4'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_CHECK: begin
                if (game_done) begin
                    state_d = S_TALLY;
                end else if (step_q < MAX_STEPS) begin
                    state_d = S_STEP_LO;
                    timer_d = hp_q - 16'd1;
                end else begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end
            end
            S_TALLY: begin
                // A result with no winner is a game fault and is never counted.
                if (!player_win && !dealer_win) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    if (player_win && dealer_win) begin
                        tie_d = sat_inc(tie_q);
                    end else if (player_win) begin
                        pwin_d = sat_inc(pwin_q);
                    end else begin
                        dwin_d = sat_inc(dwin_q);
                    end
                    round_d = round_next;
                    if (stop || (num_rounds != 8'd0 && round_next == num_rounds)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RST_LO;
                        timer_d = hp_q - 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            hp_q    <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            round_q <= '0;
            pwin_q  <= '0;
            dwin_q  <= '0;
            tie_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hp_q    <= hp_d;
            step_q  <= step_d;
            err_q   <= err_d;
            round_q <= round_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
            tie_q   <= tie_d;
        end
    end

    always_comb begin
        slow_clock  = !(state_q == S_RST_LO || state_q == S_STEP_LO);
        game_resetb = !(state_q == S_RST_LO || state_q == S_RST_HI);
        busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    end

    assign err         = err_q;
    assign round_count = round_q;
    assign pwin_count  = pwin_q;
    assign dwin_count  = dwin_q;
    assign tie_count   = tie_q;

endmodule

// File: tb/tb_baccarat_autoplay.sv
// Bench for baccarat_autoplay: a scripted game model reacts to the step pulses while
// a waveform model built from round scripts is compared against the DUT every cycle.
module tb_baccarat_autoplay;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  num_rounds = 8'd0;
    logic [15:0] half_period = 16'd0;
    logic        game_done;
    logic        player_win;
    logic        dealer_win;
    logic        slow_clock;
    logic        game_resetb;
    logic        busy;
    logic        err;
    logic [7:0]  round_count;
    logic [7:0]  pwin_count;
    logic [7:0]  dwin_count;
    logic [7:0]  tie_count;

    baccarat_autoplay dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .num_rounds  (num_rounds),
        .half_period (half_period),
        .game_done   (game_done),
        .player_win  (player_win),
        .dealer_win  (dealer_win),
        .slow_clock  (slow_clock),
        .game_resetb (game_resetb),
        .busy        (busy),
        .err         (err),
        .round_count (round_count),
        .pwin_count  (pwin_count),
        .dwin_count  (dwin_count),
        .tie_count   (tie_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       sc;
        logic       rb;
        logic       bz;
        logic       er;
        logic [7:0] rc;
        logic [7:0] pw;
        logic [7:0] dw;
        logic [7:0] tc;
    } obs_t;

    localparam int TAIL = 3;

    obs_t exp_q[$];
    obs_t cmp_e;
    obs_t cmp_g;
    int   total = 0;
    int   bad = 0;
    int   trace_idx = 0;
    int   rb_low = 0;
    int   sc_falls = 0;
    logic prev_sc = 1'b1;
    int   m_rc, m_pw, m_dw, m_tc;
    logic m_er;
    int   stop_at = -1;

    // Scripted game: round r reports its result once done_arr[r] step pulses have been seen.
    int done_arr[512];
    bit pw_arr[512];
    bit dw_arr[512];
    int g_cnt = 0;
    int g_ri = -1;

    always @(posedge slow_clock or negedge game_resetb) begin
        if (!game_resetb) g_cnt = 0;
        else              g_cnt = g_cnt + 1;
    end

    always @(negedge game_resetb) g_ri = g_ri + 1;

    assign game_done  = (g_ri >= 0) && (g_cnt >= done_arr[g_ri[8:0]]);
    assign player_win = (g_ri >= 0) && pw_arr[g_ri[8:0]];
    assign dealer_win = (g_ri >= 0) && dw_arr[g_ri[8:0]];

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic push(input logic sc, input logic rb, input logic bz, input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            o.sc = sc;
            o.rb = rb;
            o.bz = bz;
            o.er = m_er;
            o.rc = m_rc[7:0];
            o.pw = m_pw[7:0];
            o.dw = m_dw[7:0];
            o.tc = m_tc[7:0];
            exp_q.push_back(o);
        end
    endtask

    // Expected output waveform of a whole session, one entry per clock after start.
    task automatic build(input int hp_in, input int nr, input int nrounds, input int stop_round);
        int hp;
        bit fin;
        bit done;
        hp = (hp_in < 2) ? 2 : hp_in;
        m_rc = 0; m_pw = 0; m_dw = 0; m_tc = 0; m_er = 1'b0;
        stop_at = -1;
        exp_q.delete();
        fin = 1'b0;
        for (int r = 0; r < nrounds && !fin; r++) begin
            done = 1'b0;
            if (r == stop_round) stop_at = exp_q.size() + hp;
            push(1'b0, 1'b0, 1'b1, hp);
            push(1'b1, 1'b0, 1'b1, hp);
            for (int s = 1; s <= 8 && !done; s++) begin
                push(1'b0, 1'b1, 1'b1, hp);
                push(1'b1, 1'b1, 1'b1, hp);
                push(1'b1, 1'b1, 1'b1, 1);
                if (done_arr[r] == s) done = 1'b1;
            end
            if (!done) begin
                m_er = 1'b1;
                push(1'b1, 1'b1, 1'b0, TAIL);
                fin = 1'b1;
            end else begin
                push(1'b1, 1'b1, 1'b1, 1);
                if (!pw_arr[r] && !dw_arr[r]) begin
                    m_er = 1'b1;
                    push(1'b1, 1'b1, 1'b0, TAIL);
                    fin = 1'b1;
                end else begin
                    if (pw_arr[r] && dw_arr[r]) m_tc = sat(m_tc);
                    else if (pw_arr[r])         m_pw = sat(m_pw);
                    else                        m_dw = sat(m_dw);
                    m_rc = sat(m_rc);
                    if ((stop_round >= 0 && r >= stop_round) || (nr != 0 && m_rc == nr)) begin
                        push(1'b1, 1'b1, 1'b0, TAIL);
                        fin = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_g = {slow_clock, game_resetb, busy, err, round_count, pwin_count, dwin_count, tie_count};
            total = total + 1;
            if (cmp_g !== cmp_e) begin
                bad = bad + 1;
                $display("FAIL trace[%0d]: got sc=%b rb=%b busy=%b err=%b rc=%0d pw=%0d dw=%0d tc=%0d, required sc=%b rb=%b busy=%b err=%b rc=%0d pw=%0d dw=%0d tc=%0d",
                         trace_idx, cmp_g.sc, cmp_g.rb, cmp_g.bz, cmp_g.er, cmp_g.rc, cmp_g.pw, cmp_g.dw, cmp_g.tc,
                         cmp_e.sc, cmp_e.rb, cmp_e.bz, cmp_e.er, cmp_e.rc, cmp_e.pw, cmp_e.dw, cmp_e.tc);
            end
            if (!game_resetb) rb_low = rb_low + 1;
            if (prev_sc && !slow_clock && game_resetb) sc_falls = sc_falls + 1;
            prev_sc = slow_clock;
            trace_idx = trace_idx + 1;
        end
    end

    task automatic chk(input string nm, input int got, input int req);
        total = total + 1;
        if (got !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic run(input string nm, input int hp, input int nr, input int nrounds,
                       input int stop_round, input bit inject);
        int c;
        @(negedge CLOCK_50);
        build(hp, nr, nrounds, stop_round);
        g_ri = -1;
        rb_low = 0;
        sc_falls = 0;
        prev_sc = 1'b1;
        trace_idx = 0;
        half_period = hp[15:0];
        num_rounds = nr[7:0];
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        c = 1;
        while (exp_q.size() > 0 && c < 20000) begin
            @(negedge CLOCK_50);
            c = c + 1;
            if (c == stop_at) stop = 1'b1;
            start = inject && (c == 5);
        end
        total = total + 1;
        if (exp_q.size() > 0) begin
            bad = bad + 1;
            $display("FAIL %s_timeout: got %0d trace cycles left, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        stop = 1'b0;
        start = 1'b0;
        $display("scenario %s: cycles=%0d rounds=%0d pwin=%0d dwin=%0d tie=%0d err=%b busy=%b",
                 nm, c, round_count, pwin_count, dwin_count, tie_count, err, busy);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge CLOCK_50);
        chk("por_slow_clock", slow_clock, 1);
        chk("por_game_resetb", game_resetb, 1);
        chk("por_busy", busy, 0);
        chk("por_err", err, 0);
        reset = 1'b0;

        // Reset in the middle of a step-low pulse.
        done_arr[0] = 9;
        g_ri = -1;
        half_period = 16'd4;
        num_rounds = 8'd1;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        w = 0;
        while (!(slow_clock == 1'b0 && game_resetb == 1'b1) && w < 200) begin
            @(negedge CLOCK_50);
            w = w + 1;
        end
        chk("reach_step_lo", w < 200, 1);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("rst_slow_clock", slow_clock, 1);
        chk("rst_game_resetb", game_resetb, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_counters", {round_count, pwin_count, dwin_count, tie_count}, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("rst_stays_idle", busy, 0);
        $display("scenario reset: busy=%b slow_clock=%b game_resetb=%b", busy, slow_clock, game_resetb);

        // Single round, player win after the sixth step.
        done_arr[0] = 6; pw_arr[0] = 1'b1; dw_arr[0] = 1'b0;
        run("single", 4, 1, 1, -1, 1'b0);
        chk("single_rb_low_cycles", rb_low, 8);
        chk("single_step_pulses", sc_falls, 6);
        chk("single_pwin", pwin_count, 1);
        chk("single_rounds", round_count, 1);
        chk("single_busy", busy, 0);

        // Three ties reaching the round limit; a start mid-session must be ignored.
        done_arr[0] = 2; done_arr[1] = 4; done_arr[2] = 1;
        for (int i = 0; i < 3; i++) begin pw_arr[i] = 1'b1; dw_arr[i] = 1'b1; end
        run("tie", 3, 3, 3, -1, 1'b1);
        chk("tie_count", tie_count, 3);
        chk("tie_rounds", round_count, 3);
        chk("tie_pwin", pwin_count, 0);
        chk("tie_dwin", dwin_count, 0);
        chk("tie_busy", busy, 0);

        // Game never finishes the round.
        done_arr[0] = 9;
        run("timeout", 3, 5, 1, -1, 1'b0);
        chk("timeout_step_pulses", sc_falls, 8);
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_rounds", round_count, 0);

        // Unlimited rounds, stop raised during round two.
        done_arr[0] = 3; pw_arr[0] = 1'b0; dw_arr[0] = 1'b1;
        done_arr[1] = 2; pw_arr[1] = 1'b1; dw_arr[1] = 1'b0;
        done_arr[2] = 1; pw_arr[2] = 1'b1; dw_arr[2] = 1'b0;
        run("stop", 2, 0, 3, 1, 1'b0);
        chk("stop_rounds", round_count, 2);
        chk("stop_pwin", pwin_count, 1);
        chk("stop_dwin", dwin_count, 1);
        chk("stop_err", err, 0);
        chk("stop_busy", busy, 0);

        // Result reported with no winner.
        done_arr[0] = 2; pw_arr[0] = 1'b0; dw_arr[0] = 1'b0;
        run("invalid", 2, 2, 1, -1, 1'b0);
        chk("invalid_err", err, 1);
        chk("invalid_counters", {round_count, pwin_count, dwin_count, tie_count}, 0);

        // Clamped half period and saturation past 255 rounds.
        for (int i = 0; i < 257; i++) begin done_arr[i] = 1; pw_arr[i] = 1'b1; dw_arr[i] = 1'b0; end
        run("saturate", 0, 0, 257, 256, 1'b0);
        chk("sat_pwin", pwin_count, 255);
        chk("sat_rounds", round_count, 255);
        chk("sat_step_pulses", sc_falls, 257);
        chk("sat_rb_low_cycles", rb_low, 1028);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baccarat_autoplay.md
BACCARAT_AUTOPLAY -- requirements
Module: baccarat_autoplay

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports are listed below, clock and reset first.
REQ-002 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous reset, active-high.
REQ-004 start  in  1  single-cycle request to begin a play session; sampled only in IDLE, DONE or ERROR.
REQ-005 stop  in  1  level; when high, the session ends after the current round is tallied.
REQ-006 num_rounds  in  8  rounds per session; 0 means unlimited (play until stop).
REQ-007 half_period  in  16  CLOCK_50 cycles per half of a step pulse; values below 2 are treated as 2; sampled at start.
REQ-008 game_done  in  1  from game: round result is valid.
REQ-009 player_win  in  1  from game (LEDR[8]).
REQ-010 dealer_win  in  1  from game (LEDR[9]); both wins high means a tie.
REQ-011 slow_clock  out  1  step strobe to game (KEY[0] equivalent); idles high.
REQ-012 game_resetb  out  1  active-low game reset (KEY[3] equivalent); idles high.
REQ-013 busy  out  1  high while a session is in progress.
REQ-014 err  out  1  sticky error flag.
REQ-015 round_count, pwin_count, dwin_count, tie_count  out  8 each  session statistics.

Function
REQ-016 FSM states: IDLE, RST_LO, RST_HI, STEP_LO, STEP_HI, CHECK, TALLY, DONE, ERROR.
REQ-017 Each *_LO and *_HI state lasts exactly half_period cycles, timed by a 16-bit down-counter reloaded on entry.
REQ-018 slow_clock is 0 in RST_LO and STEP_LO and 1 in all other states; game_resetb is 0 in RST_LO and RST_HI only.
REQ-019 On start in IDLE, DONE or ERROR: the next cycle enters RST_LO, clears all four counters and err, and sets busy=1.
REQ-020 RST_LO -> RST_HI -> STEP_LO -> STEP_HI -> CHECK.
REQ-021 CHECK (1 cycle) samples game_done:
  - 1: go to TALLY.
  - 0 and fewer than 8 steps issued this round: go to STEP_LO.
  - 0 after 8 steps: set err=1 and go to ERROR.
REQ-022 The per-round step counter (4 bits) clears in RST_LO and increments on each STEP_HI exit.
REQ-023 TALLY (1 cycle):
  - both wins high: tie_count+1.
  - player_win only: pwin_count+1.
  - dealer_win only: dwin_count+1.
  - neither high: set err=1 and go to ERROR without counting.
REQ-024 All counters saturate at 255 and never wrap.
REQ-025 On a valid tally, round_count+1, then:
  - go to DONE if stop=1, or if num_rounds!=0 and the new round_count==num_rounds.
  - otherwise go to RST_LO.
REQ-026 stop asserted at any time is acted on only at TALLY; a round in flight always completes.
REQ-027 DONE and ERROR set busy=0 and hold all counters; err stays 1 in ERROR until reset or start.
REQ-028 start while busy=1 is ignored.
REQ-029 If round_count is saturated at 255 with num_rounds=0, play continues and round_count holds at 255.

Reset
REQ-030 reset=1 at any clock edge, including mid-pulse, forces IDLE with slow_clock=1, game_resetb=1, busy=0, err=0, all counters=0, and the timing and step counters=0, on the next cycle.
REQ-031 reset has priority over start, stop and all FSM transitions.

Verification
REQ-032 Reset: assert reset mid-STEP_LO -> next cycle slow_clock=1, game_resetb=1, busy=0, all counters 0.
REQ-033 Single round: half_period=4, num_rounds=1, game_done with player_win only after step 6 -> the sequence is one 8-cycle game_resetb-low window, then 6 slow_clock pulses of 4 low + 4 high cycles; then pwin_count=1, round_count=1, busy=0, DONE.
REQ-034 Tie and limit: num_rounds=3, game reports both wins every round -> tie_count=3, round_count=3, pwin_count=0, dwin_count=0, then DONE.
REQ-035 Timeout: game_done never asserted -> exactly 8 step pulses, then err=1, busy=0, round_count=0.
REQ-036 Stop and invalid result: num_rounds=0, stop raised mid-round 2 -> round 2 tallies, round_count=2, DONE; separately, game_done with no winner -> err=1, no counter increments.
REQ-037 Clamp and saturation: half_period=0 -> 2-cycle half pulses; forced counter at 255 with a player win -> pwin_count stays 255.
